ofm_addr_gen: RTL and testbench

Parametrised output-feature-map address generator for the systolic array write-back path. It is the successor to the fixed 16-channel OFM address controller. It walks a whole layer: pixel tiles of SYSTOLIC_SIZE, channel groups of SYSTOLIC_SIZE, a configurable channel count and base address. One address burst is issued per write request over a valid/ready handshake, and completion is signalled per layer.

---
 rtl/ofm_addr_if.sv | 10 +
 rtl/ofm_addr_gen.sv | 110 +++++++++++
 tb/tb_ofm_addr_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ofm_addr_if.sv
// ofm_addr_if: control pulses and address stream of the OFM write-back address generator
interface ofm_addr_if #(parameter int ADDR_WIDTH = 22);
  logic start, write, addr_ready;
  logic [ADDR_WIDTH-1:0] ofm_addr;
  logic addr_valid, addr_last, busy, layer_done, write_overrun;
  modport master (input start, write, addr_ready,
                  output ofm_addr, addr_valid, addr_last, busy, layer_done, write_overrun);
  modport slave (output start, write, addr_ready,
                 input ofm_addr, addr_valid, addr_last, busy, layer_done, write_overrun);
endinterface

// File: rtl/ofm_addr_gen.sv
// ofm_addr_gen: walks a layer's pixel tiles and channel groups, one address burst per write request
// Define OFM_ADDR_CH_MASK_EN to allow NUM_CHANNEL that is not a multiple of SYSTOLIC_SIZE.
module ofm_addr_gen #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_SIZE = 32,
  parameter int NUM_CHANNEL = 32,
  parameter int OFM_BASE = 0,
  parameter int ADDR_WIDTH = 22
) (
  input logic clk,
  input logic rst,
  ofm_addr_if.master bus
);
  localparam int PIX = OFM_SIZE * OFM_SIZE;
  localparam int GROUPS = (NUM_CHANNEL + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int SW = $clog2(SYSTOLIC_SIZE);
  localparam int GW = $clog2(GROUPS) + 1;
  localparam int PW = $clog2(PIX) + 1;
  localparam int CW = ADDR_WIDTH + SW;
  typedef enum logic [2:0] {IDLE, WAIT_WRITE, BURST, ADVANCE, DONE} state_t;
  state_t state;
  logic [PW-1:0] pix_base;
  logic [GW-1:0] ch_group;
  logic [SW-1:0] ch_cnt, ch_nxt, last_idx;
  logic pending, tile_end, group_end;
`ifdef OFM_ADDR_CH_MASK_EN
  localparam int LAST_LEN = NUM_CHANNEL - (GROUPS - 1) * SYSTOLIC_SIZE;
  assign last_idx = (ch_group == GW'(GROUPS - 1)) ? SW'(LAST_LEN - 1) : SW'(SYSTOLIC_SIZE - 1);
`else
  assign last_idx = SW'(SYSTOLIC_SIZE - 1);
  if (NUM_CHANNEL % SYSTOLIC_SIZE != 0) begin : g_cfg_err
    $error("ofm_addr_gen: NUM_CHANNEL must be a multiple of SYSTOLIC_SIZE");
  end
`endif
  assign ch_nxt = ch_cnt + SW'(1);
  assign tile_end = pix_base + PW'(SYSTOLIC_SIZE) == PW'(PIX);
  assign group_end = ch_group == GW'(GROUPS - 1);
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [GW-1:0] g, input logic [SW-1:0] c,
                                                    input logic [PW-1:0] p);
    logic [CW-1:0] ch, a;
    ch = CW'(g) * CW'(SYSTOLIC_SIZE) + CW'(c);
    a = CW'(OFM_BASE) + ch * CW'(PIX) + CW'(p);
    return a[ADDR_WIDTH-1:0];
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pix_base <= '0;
      ch_group <= '0;
      ch_cnt <= '0;
      pending <= 1'b0;
      bus.ofm_addr <= '0;
      bus.addr_valid <= 1'b0;
      bus.addr_last <= 1'b0;
      bus.busy <= 1'b0;
      bus.layer_done <= 1'b0;
      bus.write_overrun <= 1'b0;
    end else begin
      // one request may queue behind the active burst; a second one is dropped and flagged
      if ((state == BURST || state == ADVANCE) && bus.write) begin
        if (pending) bus.write_overrun <= 1'b1;
        pending <= 1'b1;
      end
      case (state)
        IDLE: if (bus.start) begin
          state <= WAIT_WRITE;
          pix_base <= '0;
          ch_group <= '0;
          ch_cnt <= '0;
          pending <= 1'b0;
          bus.busy <= 1'b1;
          bus.write_overrun <= 1'b0;
        end
        WAIT_WRITE: if (bus.write || pending) begin
          state <= BURST;
          pending <= pending && bus.write;
          ch_cnt <= '0;
          bus.ofm_addr <= addr_of(ch_group, '0, pix_base);
          bus.addr_valid <= 1'b1;
          bus.addr_last <= last_idx == '0;
        end
        BURST: if (bus.addr_ready) begin
          if (bus.addr_last) begin
            state <= ADVANCE;
            bus.addr_valid <= 1'b0;
            bus.addr_last <= 1'b0;
          end else begin
            ch_cnt <= ch_nxt;
            bus.ofm_addr <= addr_of(ch_group, ch_nxt, pix_base);
            bus.addr_last <= ch_nxt == last_idx;
          end
        end
        ADVANCE: begin
          ch_cnt <= '0;
          pix_base <= tile_end ? '0 : pix_base + PW'(SYSTOLIC_SIZE);
          ch_group <= tile_end ? (group_end ? '0 : ch_group + GW'(1)) : ch_group;
          state <= (tile_end && group_end) ? DONE : WAIT_WRITE;
          bus.layer_done <= tile_end && group_end;
          bus.busy <= !(tile_end && group_end);
        end
        DONE: begin
          state <= IDLE;
          pending <= 1'b0;
          bus.layer_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofm_addr_gen.sv
// tb_ofm_addr_gen: scoreboard bench, SYS=4 OFM=4 with 8 channels (6 when OFM_ADDR_CH_MASK_EN is defined)
`timescale 1ns/1ps
module tb_ofm_addr_gen;
  localparam int SYS = 4, OFM = 4, AW = 22;
`ifdef OFM_ADDR_CH_MASK_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 8;
`endif
  typedef struct {int addr; bit last;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  ofm_addr_if #(.ADDR_WIDTH(AW)) bus();
  ofm_addr_gen #(.SYSTOLIC_SIZE(SYS), .OFM_SIZE(OFM), .NUM_CHANNEL(NCH), .OFM_BASE(0), .ADDR_WIDTH(AW))
    dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0, n_fail = 0, done_cnt = 0;
  logic stall_prev = 1'b0, stall_last;
  logic [AW-1:0] stall_addr;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        check("hold_valid", bus.addr_valid, 1);
        check("hold_addr", bus.ofm_addr, stall_addr);
        check("hold_last", bus.addr_last, stall_last);
      end
      stall_prev = bus.addr_valid && !bus.addr_ready;
      stall_addr = bus.ofm_addr;
      stall_last = bus.addr_last;
      if (bus.layer_done) done_cnt++;
      if (bus.addr_valid && bus.addr_ready) begin
        check("hs_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("addr", bus.ofm_addr, mon_e.addr);
          check("last", bus.addr_last, mon_e.last);
        end
      end
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic pulse_start(); tick(); bus.start = 1'b1; tick(); bus.start = 1'b0; endtask
  task automatic pulse_write(); tick(); bus.write = 1'b1; tick(); bus.write = 1'b0; endtask
  task automatic push(input int a, input bit l); exp_q.push_back('{a, l}); endtask
  function automatic int blen(input int g);
    return (g == (NCH + SYS - 1) / SYS - 1) ? NCH - g * SYS : SYS;
  endfunction
  task automatic expect_burst(input int p, input int g);
    for (int c = 0; c < blen(g); c++) push((g * SYS + c) * OFM * OFM + p, c == blen(g) - 1);
  endtask
  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask
  task automatic issue(input int p, input int g);
    repeat (2) tick();
    expect_burst(p, g);
    pulse_write();
    drain("burst");
  endtask
  task automatic finish_layer(input string name);
    int d0;
    d0 = done_cnt;
    drain(name);
    @(negedge clk); #1;
    check({name, "_adv_done"}, bus.layer_done, 0);
    check({name, "_adv_busy"}, bus.busy, 1);
    check({name, "_adv_valid"}, bus.addr_valid, 0);
    @(negedge clk); #1;
    check({name, "_done"}, bus.layer_done, 1);
    check({name, "_done_busy"}, bus.busy, 0);
    @(negedge clk); #1;
    check({name, "_done_low"}, bus.layer_done, 0);
    check({name, "_done_count"}, done_cnt - d0, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.start = 1'b0;
    bus.write = 1'b0;
    bus.addr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outputs", {bus.ofm_addr, bus.addr_valid, bus.addr_last, bus.busy, bus.layer_done,
                          bus.write_overrun}, 0);
    tick();
    rst = 1'b0;
    pulse_write();
    repeat (3) tick();
    check("idle_write_ignored", bus.addr_valid, 0);
    pulse_start();
    check("busy_start", bus.busy, 1);
    repeat (2) tick();
    push(0, 0); push(16, 0); push(32, 0); push(48, 1);
    pulse_write();
    repeat (4) @(negedge clk);
    #1 check("t1_consecutive", exp_q.size(), 0);
    repeat (2) tick();
    push(4, 0); push(20, 0); push(36, 0); push(52, 1);
    pulse_write();
    drain("t1_second");
    issue(8, 0);
    issue(12, 0);
    repeat (2) tick();
`ifdef OFM_ADDR_CH_MASK_EN
    push(64, 0); push(80, 1);
`else
    push(64, 0); push(80, 0); push(96, 0); push(112, 1);
`endif
    pulse_write();
    drain("t2_fifth");
    issue(4, 1);
    issue(8, 1);
    repeat (2) tick();
`ifdef OFM_ADDR_CH_MASK_EN
    push(76, 0); push(92, 1);
`else
    push(76, 0); push(92, 0); push(108, 0); push(124, 1);
`endif
    pulse_write();
    finish_layer("layer1");
    pulse_start();
    check("overrun_start", bus.write_overrun, 0);
    repeat (2) tick();
    expect_burst(0, 0);
    pulse_write();
    tick();
    bus.addr_ready = 1'b0;
    @(negedge clk); #1;
    check("bp_valid", bus.addr_valid, 1);
    check("bp_addr", bus.ofm_addr, 16);
    repeat (3) @(posedge clk);
    #1 bus.addr_ready = 1'b1;
    drain("bp");
    repeat (2) tick();
    expect_burst(4, 0);
    expect_burst(8, 0);
    pulse_write();
    pulse_write();
    check("overrun_clear_pending", bus.write_overrun, 0);
    pulse_write();
    tick();
    check("overrun_set", bus.write_overrun, 1);
    drain("queued");
    issue(12, 0);
    for (int p = 0; p < 12; p += 4) issue(p, 1);
    repeat (2) tick();
    expect_burst(12, 1);
    pulse_write();
    finish_layer("layer2");
    check("overrun_sticky", bus.write_overrun, 1);
    pulse_start();
    check("overrun_cleared", bus.write_overrun, 0);
    repeat (2) tick();
    push(0, 0); push(16, 0);
    pulse_write();
    tick();
    tick();
    check("pre_rst_addr", bus.ofm_addr, 32);
    rst = 1'b1;
    #1 check("async_rst", {bus.ofm_addr, bus.addr_valid, bus.addr_last, bus.busy, bus.layer_done,
                            bus.write_overrun}, 0);
    check("pre_rst_hs", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    pulse_start();
    check("busy_restart", bus.busy, 1);
    issue(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
